// File: rtl/attendance_tracker_multi.sv
// Per-student attendance tracker: shared lecture counter, per-student attended
// counters, and a handshaked status query computed with a restoring divider.
//
// state  | meaning
// IDLE   | ready to accept a query
// CALC   | form P = A*REQ_DEN and Q = T*REQ_NUM, pick dividend/divisor
// DIV    | NW restoring steps, then one finalize step (ceil, FA update)
// RESP   | response held until resp_ready
module attendance_tracker_multi #(
    parameter int N_STUDENTS   = 8,
    parameter int TERM_CLASSES = 26,
    parameter int REQ_NUM      = 3,
    parameter int REQ_DEN      = 4
) (
    input  logic                                                   clk,
    input  logic                                                   clr_n,
    input  logic                                                   class_valid,
    input  logic [N_STUDENTS-1:0]                                  present,
    input  logic                                                   new_term,
    input  logic                                                   query_valid,
    input  logic [$clog2(N_STUDENTS)-1:0]                          query_id,
    output logic                                                   query_ready,
    output logic                                                   resp_valid,
    input  logic                                                   resp_ready,
    output logic [$clog2(TERM_CLASSES+1)-1:0]                      resp_total,
    output logic [$clog2(TERM_CLASSES+1)-1:0]                      resp_attended,
    output logic                                                   resp_safe,
    output logic [$clog2(TERM_CLASSES+1)-1:0]                      resp_leaves,
    output logic [$clog2(TERM_CLASSES+1)+$clog2(REQ_DEN+1)-1:0]    resp_to_attend,
    output logic                                                   resp_fa,
    output logic                                                   term_done
);
    localparam int IW   = $clog2(N_STUDENTS);
    localparam int CW   = $clog2(TERM_CLASSES + 1);
    localparam int DW   = $clog2(REQ_DEN + 1);
    localparam int NW   = CW + DW;
    localparam int CNTW = $clog2(NW + 1);
    localparam logic [NW-1:0] DEN_W  = NW'(REQ_DEN);
    localparam logic [NW-1:0] NUM_W  = NW'(REQ_NUM);
    localparam logic [NW-1:0] GAP_W  = NW'(REQ_DEN - REQ_NUM);
    localparam logic [NW-1:0] TERM_W = NW'(TERM_CLASSES);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   total_q, total_d;
    logic [CW-1:0]   att_q [N_STUDENTS];
    logic [CW-1:0]   att_d [N_STUDENTS];
    logic [N_STUDENTS-1:0] fa_q, fa_d;
    logic [CW-1:0]   t_q, t_d, a_q, a_d;
    logic [IW-1:0]   id_q, id_d;
    logic            safe_q, safe_d;
    logic [NW-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
    logic [NW:0]     rem_q, rem_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   leaves_q, leaves_d;
    logic [NW-1:0]   ta_q, ta_d;
    logic            rfa_q, rfa_d;

    logic [CW-1:0]   a_sel;
    logic            fa_sel, fa_set;
    logic [NW-1:0]   p, q, to_att, remain;
    logic [NW:0]     rem_sh;

    assign term_done      = (total_q == CW'(TERM_CLASSES));
    assign query_ready    = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_RESP);
    assign resp_total     = t_q;
    assign resp_attended  = a_q;
    assign resp_safe      = safe_q;
    assign resp_leaves    = leaves_q;
    assign resp_to_attend = ta_q;
    assign resp_fa        = rfa_q;

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        att_d    = att_q;
        fa_d     = fa_q;
        t_d      = t_q;
        a_d      = a_q;
        id_d     = id_q;
        safe_d   = safe_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        leaves_d = leaves_q;
        ta_d     = ta_q;
        rfa_d    = rfa_q;
        a_sel    = '0;
        fa_sel   = 1'b0;
        fa_set   = 1'b0;
        for (int i = 0; i < N_STUDENTS; i++) begin
            if (IW'(i) == query_id) a_sel = att_q[i];
            if (IW'(i) == id_q)     fa_sel = fa_q[i];
        end
        p      = NW'(a_q) * DEN_W;
        q      = NW'(t_q) * NUM_W;
        rem_sh = {rem_q[NW-1:0], dvd_q[NW-1]};
        to_att = dvd_q + {{(NW-1){1'b0}}, |rem_q};
        remain = TERM_W - NW'(t_q);

        case (state_q)
            S_IDLE: begin
                if (query_valid) begin
                    t_d     = total_q;
                    a_d     = a_sel;
                    id_d    = query_id;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (p >= q) begin
                    safe_d = 1'b1;
                    dvd_d  = p - q;
                    dvs_d  = NUM_W;
                end else begin
                    safe_d = 1'b0;
                    dvd_d  = q - p;
                    dvs_d  = GAP_W;
                end
                rem_d   = '0;
                cnt_d   = CNTW'(NW);
                state_d = S_DIV;
            end
            S_DIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (rem_sh >= {1'b0, dvs_q}) begin
                        rem_d = rem_sh - {1'b0, dvs_q};
                        dvd_d = {dvd_q[NW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        dvd_d = {dvd_q[NW-2:0], 1'b0};
                    end
                end else begin
                    // dvd_q now holds the quotient, rem_q the remainder
                    if (safe_q) begin
                        leaves_d = CW'(dvd_q);
                        ta_d     = '0;
                    end else begin
                        leaves_d = '0;
                        ta_d     = to_att;
                        fa_set   = (to_att > remain);
                    end
                    for (int i = 0; i < N_STUDENTS; i++) begin
                        if (fa_set && IW'(i) == id_q) fa_d[i] = 1'b1;
                    end
                    rfa_d   = fa_sel | fa_set;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (new_term) begin
            total_d = '0;
            att_d   = '{default: '0};
            fa_d    = '0;
        end else if (class_valid && !term_done) begin
            total_d = total_q + CW'(1);
            for (int i = 0; i < N_STUDENTS; i++) begin
                att_d[i] = att_q[i] + CW'(present[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            total_q  <= '0;
            att_q    <= '{default: '0};
            fa_q     <= '0;
            t_q      <= '0;
            a_q      <= '0;
            id_q     <= '0;
            safe_q   <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            leaves_q <= '0;
            ta_q     <= '0;
            rfa_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            att_q    <= att_d;
            fa_q     <= fa_d;
            t_q      <= t_d;
            a_q      <= a_d;
            id_q     <= id_d;
            safe_q   <= safe_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            leaves_q <= leaves_d;
            ta_q     <= ta_d;
            rfa_q    <= rfa_d;
        end
    end
endmodule

// File: tb/tb_attendance_tracker_multi.sv
// Scoreboard bench for attendance_tracker_multi: an arithmetic reference model
// predicts each response; a negedge monitor pops and compares on handshake.
module tb_attendance_tracker_multi;
    localparam int N    = 8;
    localparam int TERM = 26;
    localparam int RN   = 3;
    localparam int RD   = 4;
    localparam int IW   = 3;
    localparam int CW   = 5;
    localparam int NW   = 8;
    localparam int LAT  = NW + 2;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic            class_valid = 1'b0;
    logic [N-1:0]    present = '0;
    logic            new_term = 1'b0;
    logic            query_valid = 1'b0;
    logic [IW-1:0]   query_id = '0;
    logic            query_ready;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [CW-1:0]   resp_total, resp_attended, resp_leaves;
    logic            resp_safe, resp_fa, term_done;
    logic [NW-1:0]   resp_to_attend;

    attendance_tracker_multi #(.N_STUDENTS(N), .TERM_CLASSES(TERM), .REQ_NUM(RN), .REQ_DEN(RD)) dut (
        .clk(clk), .clr_n(clr_n), .class_valid(class_valid), .present(present),
        .new_term(new_term), .query_valid(query_valid), .query_id(query_id),
        .query_ready(query_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_total(resp_total), .resp_attended(resp_attended), .resp_safe(resp_safe),
        .resp_leaves(resp_leaves), .resp_to_attend(resp_to_attend), .resp_fa(resp_fa),
        .term_done(term_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t; int a; int safe; int leaves; int ta; int fa; int acc;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int m_tot = 0;
    int m_att[N];
    bit m_fa[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        m_tot = 0;
        for (int i = 0; i < N; i++) begin
            m_att[i] = 0;
            m_fa[i]  = 1'b0;
        end
    endfunction

    function automatic void m_class(input logic [N-1:0] pres);
        if (m_tot < TERM) begin
            m_tot++;
            for (int i = 0; i < N; i++) m_att[i] += int'(pres[i]);
        end
    endfunction

    // Safe when attended/total >= RN/RD; leaves and to_attend from the fraction rule
    function automatic exp_t m_query(input int id);
        exp_t e;
        int pp, qq;
        e.t = m_tot;
        e.a = m_att[id];
        pp = e.a * RD;
        qq = e.t * RN;
        if (pp >= qq) begin
            e.safe = 1; e.leaves = (pp - qq) / RN; e.ta = 0;
        end else begin
            e.safe = 0; e.leaves = 0; e.ta = (qq - pp + (RD - RN) - 1) / (RD - RN);
            if (e.ta > TERM - e.t) m_fa[id] = 1'b1;
        end
        e.fa = int'(m_fa[id]);
        e.acc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_class(input logic [N-1:0] pres);
        class_valid = 1'b1;
        present = pres;
        tick();
        m_class(pres);
        class_valid = 1'b0;
    endtask

    task automatic pulse_new_term(input bit with_class);
        new_term = 1'b1;
        class_valid = with_class;
        present = N'($urandom);
        tick();
        m_clear();
        new_term = 1'b0;
        class_valid = 1'b0;
    endtask

    task automatic do_query(input int id, input bit with_class, input logic [N-1:0] pres, input int hold);
        exp_t e;
        int w;
        chk("query_ready_idle", query_ready, 1);
        query_valid = 1'b1;
        query_id = IW'(id);
        class_valid = with_class;
        present = pres;
        e = m_query(id);
        tick();
        e.acc = cyc;
        sb.push_back(e);
        if (with_class) m_class(pres);
        query_valid = 1'b0;
        class_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 40) begin
            tick();
            w++;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 0, 1);
            sb.delete();
            return;
        end
        query_valid = (hold > 0);
        query_id = IW'($urandom);
        repeat (hold) tick();
        query_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    logic        pv = 1'b0;
    logic [31:0] snap;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] cur;
        cur = {7'd0, resp_total, resp_attended, resp_safe, resp_leaves, resp_to_attend, resp_fa};
        if (clr_n) chk("term_done", term_done, m_tot == TERM);
        if (resp_valid) begin
            if (!pv) begin
                if (sb.size() == 0) chk("unexpected_resp", 1, 0);
                else chk("latency", cyc - sb[0].acc, LAT);
                snap = cur;
            end else begin
                chk("resp_stable", cur, snap);
            end
            chk("no_accept_in_resp", query_ready, 0);
            if (resp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("resp_total", resp_total, e.t);
                chk("resp_attended", resp_attended, e.a);
                chk("resp_safe", resp_safe, e.safe);
                chk("resp_leaves", resp_leaves, e.leaves);
                chk("resp_to_attend", resp_to_attend, e.ta);
                chk("resp_fa", resp_fa, e.fa);
            end
        end
        pv <= resp_valid;
    end

    initial begin
        bit seen;
        m_clear();
        #23;
        chk("rst_query_ready", query_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_term_done", term_done, 0);
        chk("rst_resp_bus", {resp_total, resp_attended, resp_safe, resp_leaves, resp_to_attend, resp_fa}, 0);
        clr_n = 1'b1;
        tick();
        chk("idle_resp_valid", resp_valid, 0);

        repeat (4) pulse_class(8'h01);
        do_query(0, 1'b0, '0, 0);
        do_query(1, 1'b0, '0, 0);

        pulse_new_term(1'b0);
        repeat (8) pulse_class(N'($urandom) & 8'hFB);
        do_query(2, 1'b0, '0, 0);
        pulse_class(8'h04);
        do_query(2, 1'b0, '0, 0);
        pulse_new_term(1'b0);
        do_query(2, 1'b0, '0, 0);

        pulse_new_term(1'b1);
        for (int i = 0; i < 27; i++) begin
            if (i == 10) do_query($urandom_range(0, N - 1), 1'b1, N'($urandom), 0);
            else pulse_class(N'($urandom));
        end
        for (int i = 0; i < 4; i++) do_query(i, 1'b0, '0, 0);
        do_query(5, 1'b1, N'($urandom), 5);

        query_valid = 1'b1;
        query_id = 3'd1;
        tick();
        query_valid = 1'b0;
        repeat (4) tick();
        clr_n = 1'b0;
        m_clear();
        sb.delete();
        #2;
        chk("mid_rst_query_ready", query_ready, 1);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_total", resp_total, 0);
        tick();
        clr_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_reset", seen, 0);

        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op == 0) pulse_new_term($urandom_range(0, 1) == 1);
            else if (op < 11) pulse_class(N'($urandom));
            else if (op < 18) do_query($urandom_range(0, N - 1), $urandom_range(0, 1) == 1,
                                       N'($urandom), $urandom_range(0, 3));
            else tick();
        end

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
